// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master to NUM_SLAVES address-decoded bus with write protection,
// slave timeout and error reporting.
module bus_interconnect #(
    parameter int                      NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE    = {32'h20000000, 32'h10000000, 32'h00010000, 32'h00000000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK    = {32'hFFFFFF00, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFF000},
    parameter logic [NUM_SLAVES-1:0]    SLAVE_RO      = 4'b0001,
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_valid,
    input  logic                       m_instr,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wstrb,
    output logic                       m_ready,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic                       bus_err,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_count
);
    localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
    state_t state;
    logic [IW-1:0] idx, sel;
    logic [NUM_SLAVES-1:0] onehot;
    logic [15:0] wait_cnt;
    logic hit, bad_req;
    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*32 +: 32]) == (SLAVE_BASE[i*32 +: 32] & SLAVE_MASK[i*32 +: 32])) begin
                hit = 1'b1;
                idx = i[IW-1:0];
            end
        end
        onehot = '0;
        onehot[idx] = 1'b1;
    end
    // Instruction fetches are always allowed, even into protected regions.
    assign bad_req = ~hit | ((|m_wstrb) & ~m_instr & SLAVE_RO[idx]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            wait_cnt  <= '0;
            s_valid   <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            m_ready   <= 1'b0;
            m_rdata   <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            m_ready <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: if (m_valid) begin
                    s_addr   <= m_addr;
                    s_wdata  <= m_wdata;
                    s_wstrb  <= m_wstrb;
                    sel      <= idx;
                    wait_cnt <= '0;
                    if (bad_req) begin
                        state     <= ERR;
                        m_ready   <= 1'b1;
                        bus_err   <= 1'b1;
                        m_rdata   <= ERR_RDATA;
                        err_addr  <= m_addr;
                        err_count <= err_count + 8'(err_count != 8'hFF);
                    end else begin
                        state   <= ACCESS;
                        s_valid <= onehot;
                    end
                end
                ACCESS: if (s_ready[sel]) begin
                    state   <= RESP;
                    s_valid <= '0;
                    m_ready <= 1'b1;
                    m_rdata <= s_rdata[sel*32 +: 32];
                end else if (wait_cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                    state     <= ERR;
                    s_valid   <= '0;
                    m_ready   <= 1'b1;
                    bus_err   <= 1'b1;
                    m_rdata   <= ERR_RDATA;
                    err_addr  <= s_addr;
                    err_count <= err_count + 8'(err_count != 8'hFF);
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: directed requests with a queue scoreboard checked by an independent
// response monitor; a behavioural slave model answers with per-slave latency.
module tb_bus_interconnect;
    logic clk = 1'b0, rst = 1'b1;
    logic m_valid = 1'b0, m_instr = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0] m_wstrb = '0;
    logic m_ready, bus_err;
    logic [31:0] m_rdata, s_addr, s_wdata, err_addr;
    logic [3:0] s_valid, s_wstrb, s_ready = '0;
    logic [127:0] s_rdata;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    bus_interconnect #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .bus_err(bus_err), .err_addr(err_addr),
        .err_count(err_count)
    );

    typedef struct {logic [31:0] rdata; logic err; logic [31:0] eaddr; logic [7:0] ecnt;} exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0, bad = 0;
    int lat[4] = '{0, 0, 0, 0};
    int vcnt[4] = '{0, 0, 0, 0};
    logic [31:0] sdat[4] = '{32'h0000C0DE, 32'h11111111, 32'h12345678, 32'h33333333};
    logic noise = 1'b0;
    int exp_cnt = 0;
    int latn, vcyc;
    logic [3:0] vseen, sws;
    logic [31:0] saddr, swd;

    assign s_rdata = {sdat[3], sdat[2], sdat[1], sdat[0]};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Slave model: a selected slave answers lat[k] cycles after s_valid rises (negative = never).
    always @(negedge clk)
        for (int k = 0; k < 4; k++)
            if (s_valid[k]) begin
                s_ready[k] = (lat[k] >= 0) && (vcnt[k] >= lat[k]);
                vcnt[k]++;
            end else begin
                s_ready[k] = noise;
                vcnt[k] = 0;
            end

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk)
        if (!rst && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got m_ready=1 expected no response");
            end else begin
                e = sb.pop_front();
                chk("m_rdata", m_rdata, e.rdata);
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                if (e.err) begin
                    chk("err_addr", err_addr, e.eaddr);
                    chk("err_count", {24'd0, err_count}, {24'd0, e.ecnt});
                end
            end
        end

    function automatic void push_ok(logic [31:0] d);
        exp_t x;
        x.rdata = d; x.err = 1'b0; x.eaddr = '0; x.ecnt = '0;
        sb.push_back(x);
    endfunction

    function automatic void push_err(logic [31:0] a);
        exp_t x;
        exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
        x.rdata = 32'hDEADBEEF; x.err = 1'b1; x.eaddr = a; x.ecnt = 8'(exp_cnt);
        sb.push_back(x);
    endfunction

    task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic instr);
        bit done = 0;
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; m_instr = instr;
        @(posedge clk); #1;
        m_valid = 1'b0; m_addr = 32'h5A5A5A5A; m_wdata = 32'hFFFFFFFF; m_wstrb = 4'hF; m_instr = 1'b0;
        latn = 0; vcyc = 0; vseen = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            latn++;
            if (s_valid != 0) begin
                vcyc++; vseen = s_valid; saddr = s_addr; swd = s_wdata; sws = s_wstrb;
            end
            if (m_ready) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL resp_wait: got no m_ready within 40 cycles for addr %h", a);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_m_ready"}, {31'd0, m_ready}, 32'd0);
        chk({tag, "_s_valid"}, {28'd0, s_valid}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        chk({tag, "_m_rdata"}, m_rdata, 32'd0);
        chk({tag, "_s_addr"}, s_addr, 32'd0);
        chk({tag, "_s_wdata"}, s_wdata, 32'd0);
        chk({tag, "_s_wstrb"}, {28'd0, s_wstrb}, 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;

        push_ok(32'h12345678);
        req(32'h10000004, 32'h0, 4'h0, 1'b0);
        chk("rd2_latency", latn, 2);
        chk("rd2_svalid_cycles", vcyc, 1);
        chk("rd2_svalid", {28'd0, vseen}, 32'h4);
        chk("rd2_saddr", saddr, 32'h10000004);

        lat[1] = 1;
        push_ok(32'h11111111);
        req(32'h00010008, 32'h0, 4'h0, 1'b0);
        chk("rd1_latency", latn, 3);
        chk("rd1_svalid", {28'd0, vseen}, 32'h2);

        push_err(32'h00000010);
        req(32'h00000010, 32'hCAFEF00D, 4'hF, 1'b0);
        chk("ro_latency", latn, 1);
        chk("ro_svalid_cycles", vcyc, 0);

        push_err(32'h50000000);
        req(32'h50000000, 32'h0, 4'h0, 1'b0);
        chk("unmapped_svalid_cycles", vcyc, 0);

        push_ok(32'h0000C0DE);
        req(32'h00000100, 32'h0, 4'h0, 1'b1);
        chk("fetch_ro_svalid", {28'd0, vseen}, 32'h1);

        push_ok(32'h33333333);
        req(32'h20000010, 32'hA5A50001, 4'h3, 1'b0);
        chk("wr3_svalid", {28'd0, vseen}, 32'h8);
        chk("wr3_wdata", swd, 32'hA5A50001);
        chk("wr3_wstrb", {28'd0, sws}, 32'h3);

        noise = 1'b1;
        lat[2] = -1;
        push_err(32'h10000100);
        req(32'h10000100, 32'h0, 4'h0, 1'b0);
        chk("timeout_svalid_cycles", vcyc, 4);
        chk("timeout_latency", latn, 5);
        noise = 1'b0;
        lat[2] = 0;

        for (int i = 0; i < 300; i++) begin
            push_err(32'h50000000 + i);
            req(32'h50000000 + i, 32'h0, 4'h0, 1'b0);
        end
        chk("err_count_sat", {24'd0, err_count}, 32'd255);

        lat[1] = 3;
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h00010000; m_wstrb = 4'h0;
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(negedge clk);
        chk("pre_abort_svalid", {28'd0, s_valid}, 32'h2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1 chk_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        repeat (10) @(posedge clk);

        push_ok(32'h12345678);
        req(32'h10000004, 32'h0, 4'h0, 1'b0);
        chk("post_abort_latency", latn, 2);

        push_err(32'h40000000);
        req(32'h40000000, 32'h0, 4'h0, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
